block_dev_sdhost: RTL
=====================

Name: block_dev_sdhost

Overview:
Parametrised block-device controller for the LM-3 disk path. It keeps the existing host-side bd_* command/handshake interface and replaces the bit-level MMC/SPI engine with the MiSTer HPS sector interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*). It adds multiple units, a configurable number of sectors per block, an internal one-sector buffer, an ack timeout, and media-presence checking. It sits between the disk controller (bd_*) and the MiSTer top-level HPS I/O.

Parameters:
UNITS, 1, number of drive units/images (1..8); UW = max(1, clog2(UNITS))
SECTORS, 2, 512-byte sectors per bd block (power of two, 1..16)
ACK_TIMEOUT, 24'hFFFFFF, clk cycles to wait for sd_ack rise before error

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
bd_cmd  in  2  00 reset/clear, 01 read, 10 write, 11 illegal
bd_unit  in  UW  target unit, sampled with bd_start
bd_start  in  1  command strobe
bd_rd  in  1  host read strobe; each 0->1 edge consumes one word
bd_wr  in  1  host write strobe; each 0->1 edge supplies one word
bd_addr  in  24  block number
bd_data_in  in  16  host write data
bd_data_out  out  16  host read data
bd_state  out  12  debug: [3:0] fsm, [7:4] sector index, [8] req, [9] ack, [11:10] 0
bd_bsy  out  1  state != IDLE
bd_err  out  1  sticky error
bd_iordy  out  1  word available (read) or slot free (write)
bd_rdy  out  1  ready for command or host word
sd_lba  out  32  sector LBA for HPS
sd_rd  out  UNITS  per-unit read request
sd_wr  out  UNITS  per-unit write request
sd_ack  in  UNITS  per-unit HPS acknowledge
sd_buff_addr  in  8  HPS buffer word address
sd_buff_dout  in  16  HPS->buffer data
sd_buff_wr  in  1  HPS buffer write strobe
sd_buff_din  out  16  buffer->HPS data, registered
img_mounted  in  UNITS  unit has media

Behaviour:
- Reset (reset_n low, async): state=IDLE. All outputs 0: sd_rd, sd_wr, bd_err, bd_bsy, bd_iordy, bd_data_out, sd_lba, sd_buff_din. bd_rdy is 1 after release. Counters clear. Asserting reset mid-transfer drops sd_rd/sd_wr immediately.
- bd_start is sampled only in IDLE and ignored while busy. It latches cmd, unit and lba = bd_addr << log2(SECTORS) (32-bit, zero-extended) and clears bd_err.
- FSM states: IDLE, CHECK, HOSTRD, HOSTWR, SDREQ, SDXFER, DONE.
- IDLE -> CHECK on bd_start.
- CHECK (1 cycle):
  - cmd 00 -> DONE.
  - cmd 11, unit >= UNITS, or img_mounted[unit]=0 -> set err, DONE.
  - read -> SDREQ.
  - write -> HOSTWR with wc=0.
- SDREQ: assert sd_rd[unit] or sd_wr[unit] with sd_lba = lba + sector index. Wait for sd_ack[unit]=1, then -> SDXFER. The timeout counter runs; if it reaches ACK_TIMEOUT: set err, drop request, -> DONE.
- SDXFER: request stays high while ack is high.
  - Read: sd_buff_wr writes sd_buff_dout to buf[sd_buff_addr].
  - Write: sd_buff_din = buf[sd_buff_addr], one cycle after the address.
  - On sd_ack fall: drop request.
    - Read -> HOSTRD with wc=0.
    - Write: sector index +1; if index == SECTORS -> DONE, else -> HOSTWR.
- HOSTRD:
  - bd_data_out = buf[wc], valid with bd_iordy=1.
  - A bd_rd rising edge increments wc. bd_iordy drops for 1 cycle while the next word is fetched.
  - After word 255 is consumed: sector index +1; if index == SECTORS -> DONE, else -> SDREQ.
- HOSTWR:
  - bd_iordy=1. A bd_wr rising edge writes bd_data_in to buf[wc], wc+1.
  - After word 255: -> SDREQ.
- DONE: 1 cycle, bd_rdy=1, -> IDLE. bd_err holds until the next accepted bd_start.
- bd_rdy = IDLE | DONE | (HOSTRD|HOSTWR with bd_iordy).
- img_mounted[unit] falling in any non-IDLE state: set err, drop request, -> DONE next cycle.
- sd_buff_wr outside SDXFER-read is ignored; the buffer is not modified.
- Simultaneous sd_ack fall and sd_buff_wr: the write lands before the state advances.
- wc is 8-bit. Wrap 255 -> 0 terminates the sector and never overruns.
- Edge detection on bd_rd/bd_wr is registered. A strobe held high counts once.

Test Plan:
- Read, unit 0, bd_addr=24'h000003, SECTORS=2 -> sd_lba=6 then 7. The HPS model fills a pattern; 512 bd_rd edges return words in order; bd_err=0; bd_bsy falls after DONE.
- Write, 512 words 16'h1000+n -> sd_wr asserted after every 256th word. HPS readback via sd_buff_din matches, with 1-cycle latency.
- No sd_ack, ACK_TIMEOUT=100 -> bd_err=1 at cycle ~101 after SDREQ, sd_rd=0, state IDLE.
- bd_cmd=11, or unit 1 with img_mounted=2'b01 (UNITS=2) -> bd_err=1 within 3 cycles, no sd_rd/sd_wr activity.
- reset_n low during SDXFER -> sd_rd/sd_wr=0 asynchronously. After release: IDLE, bd_rdy=1, bd_err=0.
- bd_start while busy, and bd_rd held high 10 cycles -> command ignored; exactly one word consumed.

Source files
------------

// File: rtl/block_dev_sdhost.sv
// Block-device controller: bd_* host port to MiSTer HPS sector interface.
// One-sector buffer, multi-unit, multi-sector blocks, ack timeout, media check.
module block_dev_sdhost #(
    parameter int          UNITS       = 1,
    parameter int          SECTORS     = 2,
    parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF,
    localparam int         UW          = (UNITS > 1) ? $clog2(UNITS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       bd_cmd,
    input  logic [UW-1:0]    bd_unit,
    input  logic             bd_start,
    input  logic             bd_rd,
    input  logic             bd_wr,
    input  logic [23:0]      bd_addr,
    input  logic [15:0]      bd_data_in,
    output logic [15:0]      bd_data_out,
    output logic [11:0]      bd_state,
    output logic             bd_bsy,
    output logic             bd_err,
    output logic             bd_iordy,
    output logic             bd_rdy,
    output logic [31:0]      sd_lba,
    output logic [UNITS-1:0] sd_rd,
    output logic [UNITS-1:0] sd_wr,
    input  logic [UNITS-1:0] sd_ack,
    input  logic [7:0]       sd_buff_addr,
    input  logic [15:0]      sd_buff_dout,
    input  logic             sd_buff_wr,
    output logic [15:0]      sd_buff_din,
    input  logic [UNITS-1:0] img_mounted
);
    localparam int SH = $clog2(SECTORS);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_HOSTRD, S_HOSTWR, S_SDREQ, S_SDXFER, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [31:0] lba_q, lba_d;
    logic [4:0]  sec_q, sec_d;
    logic [7:0]  wc_q, wc_d;
    logic [23:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        rdv_q, rdv_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] din_q;
    logic        rd_q, wr_q;
    logic [15:0] buf_q [256];

    logic        ack, mnt, req, lost, host_we, hps_we, is_rd;
    logic        rd_edge, wr_edge, last_sec;
    logic [UNITS-1:0] sel;

    assign is_rd    = (cmd_q == 2'b01);
    assign rd_edge  = bd_rd & ~rd_q;
    assign wr_edge  = bd_wr & ~wr_q;
    assign last_sec = (sec_q + 5'd1 == 5'(SECTORS));
    assign req      = (state_q == S_SDREQ) || (state_q == S_SDXFER);
    assign lost     = !mnt && (state_q == S_SDREQ || state_q == S_SDXFER ||
                               state_q == S_HOSTRD || state_q == S_HOSTWR);
    assign hps_we   = (state_q == S_SDXFER) && is_rd && sd_buff_wr;

    // Select the latched unit's ack, media flag and request line
    always_comb begin
        ack = 1'b0;
        mnt = 1'b0;
        sel = '0;
        for (int i = 0; i < UNITS; i++) begin
            if (unit_q == UW'(i)) begin
                ack    = sd_ack[i];
                mnt    = img_mounted[i];
                sel[i] = 1'b1;
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        unit_d  = unit_q;
        lba_d   = lba_q;
        sec_d   = sec_q;
        wc_d    = wc_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        rdv_d   = rdv_q;
        dout_d  = dout_q;
        host_we = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bd_start) begin
                    cmd_d   = bd_cmd;
                    unit_d  = bd_unit;
                    lba_d   = 32'(bd_addr) << SH;
                    sec_d   = '0;
                    wc_d    = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    rdv_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cmd_q == 2'b00) begin
                    state_d = S_DONE;
                end else if (cmd_q == 2'b11 || !mnt) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (is_rd) begin
                    tmo_d   = '0;
                    state_d = S_SDREQ;
                end else begin
                    wc_d    = '0;
                    state_d = S_HOSTWR;
                end
            end
            S_SDREQ: begin
                if (ack) begin
                    state_d = S_SDXFER;
                end else if (tmo_q == ACK_TIMEOUT - 24'd1) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            S_SDXFER: begin
                if (!ack) begin
                    wc_d = '0;
                    if (is_rd) begin
                        rdv_d   = 1'b0;
                        state_d = S_HOSTRD;
                    end else if (last_sec) begin
                        state_d = S_DONE;
                    end else begin
                        sec_d   = sec_q + 5'd1;
                        state_d = S_HOSTWR;
                    end
                end
            end
            S_HOSTRD: begin
                if (!rdv_q) begin
                    dout_d = buf_q[wc_q];
                    rdv_d  = 1'b1;
                end else if (rd_edge) begin
                    rdv_d = 1'b0;
                    wc_d  = wc_q + 8'd1;
                    if (wc_q == 8'hFF) begin
                        if (last_sec) begin
                            state_d = S_DONE;
                        end else begin
                            sec_d   = sec_q + 5'd1;
                            tmo_d   = '0;
                            state_d = S_SDREQ;
                        end
                    end
                end
            end
            S_HOSTWR: begin
                if (wr_edge) begin
                    host_we = 1'b1;
                    wc_d    = wc_q + 8'd1;
                    if (wc_q == 8'hFF) begin
                        tmo_d   = '0;
                        state_d = S_SDREQ;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (lost) begin
            err_d   = 1'b1;
            state_d = S_DONE;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            unit_q  <= '0;
            lba_q   <= '0;
            sec_q   <= '0;
            wc_q    <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
            dout_q  <= '0;
            din_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            unit_q  <= unit_d;
            lba_q   <= lba_d;
            sec_q   <= sec_d;
            wc_q    <= wc_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            rdv_q   <= rdv_d;
            dout_q  <= dout_d;
            din_q   <= buf_q[sd_buff_addr];
            rd_q    <= bd_rd;
            wr_q    <= bd_wr;
        end
    end

    // Sector buffer: HPS fills it on reads, host fills it on writes
    always_ff @(posedge clk) begin
        if (hps_we) begin
            buf_q[sd_buff_addr] <= sd_buff_dout;
        end else if (host_we) begin
            buf_q[wc_q] <= bd_data_in;
        end
    end

    assign sd_rd       = (req && is_rd) ? sel : '0;
    assign sd_wr       = (req && cmd_q == 2'b10) ? sel : '0;
    assign sd_lba      = lba_q + {27'b0, sec_q};
    assign sd_buff_din = din_q;
    assign bd_data_out = dout_q;
    assign bd_err      = err_q;
    assign bd_bsy      = (state_q != S_IDLE);
    assign bd_iordy    = (state_q == S_HOSTWR) ||
                         (state_q == S_HOSTRD && rdv_q);
    assign bd_rdy      = (state_q == S_IDLE) || (state_q == S_DONE) ||
                         bd_iordy;
    assign bd_state    = {2'b00, ack, req, sec_q[3:0], state_q};
endmodule
